// File: rtl/odbiornik_szeregowy.sv
// Serial-to-parallel receiver fed by the upstream shift register's swy output.
// It waits for a start bit, assembles n data bits LSB-first and checks even
// parity. Each word is then presented on a valid/ready handshake.
//
// Ports:
//   zegar            clock, all state changes on posedge
//   reset            asynchronous active-low reset
//   swe              serial data bit
//   swe_wazny        bit strobe; swe is sampled only when 1
//   wyczysc          synchronous clear of przepelnienie
//   dane             received word
//   dane_wazne       dane holds an unconsumed word
//   dane_gotowe      consumer ready; transfer on dane_wazne & dane_gotowe
//   blad_parzystosci parity error of the word on dane
//   przepelnienie    sticky flag: a completed word was dropped
//   zajety           frame in progress
module odbiornik_szeregowy #(
  parameter int unsigned n = 4
) (
  input  logic         zegar,
  input  logic         reset,
  input  logic         swe,
  input  logic         swe_wazny,
  input  logic         wyczysc,
  output logic [n-1:0] dane,
  output logic         dane_wazne,
  input  logic         dane_gotowe,
  output logic         blad_parzystosci,
  output logic         przepelnienie,
  output logic         zajety
);

  localparam int unsigned LicznikW = $clog2(n);

  typedef enum logic [1:0] {
    StBezczynny,
    StDane,
    StParzystosc
  } stan_e;

  stan_e               stan_q, stan_d;
  logic [LicznikW-1:0] licznik_q, licznik_d;
  logic [n-1:0]        rejestr_q, rejestr_d;
  logic [n-1:0]        dane_q, dane_d;
  logic                wazne_q, wazne_d;
  logic                blad_q, blad_d;
  logic                przep_q, przep_d;
  logic                zatwierdz;

  // Frame FSM; everything advances only on strobe cycles.
  always_comb begin
    stan_d    = stan_q;
    licznik_d = licznik_q;
    rejestr_d = rejestr_q;
    zatwierdz = 1'b0;
    if (swe_wazny) begin
      unique case (stan_q)
        StBezczynny: begin
          if (swe) begin
            stan_d    = StDane;
            licznik_d = '0;
          end
        end
        StDane: begin
          rejestr_d = {swe, rejestr_q[n-1:1]};
          licznik_d = licznik_q + LicznikW'(1);
          if (licznik_q == LicznikW'(n - 1)) begin
            stan_d = StParzystosc;
          end
        end
        StParzystosc: begin
          zatwierdz = 1'b1;
          stan_d    = StBezczynny;
        end
        default: stan_d = StBezczynny;
      endcase
    end
  end

  // Output register and handshake. A commit lands if the slot is empty or is
  // being consumed this very cycle; otherwise the new word is dropped.
  always_comb begin
    dane_d  = dane_q;
    wazne_d = wazne_q;
    blad_d  = blad_q;
    przep_d = wyczysc ? 1'b0 : przep_q;
    if (wazne_q && dane_gotowe) begin
      wazne_d = 1'b0;
    end
    if (zatwierdz) begin
      if (!wazne_q || dane_gotowe) begin
        dane_d  = rejestr_q;
        blad_d  = ^rejestr_q ^ swe;
        wazne_d = 1'b1;
      end else begin
        przep_d = 1'b1;  // set wins over a same-cycle clear
      end
    end
  end

  always_ff @(posedge zegar or negedge reset) begin
    if (!reset) begin
      stan_q    <= StBezczynny;
      licznik_q <= '0;
      rejestr_q <= '0;
      dane_q    <= '0;
      wazne_q   <= 1'b0;
      blad_q    <= 1'b0;
      przep_q   <= 1'b0;
    end else begin
      stan_q    <= stan_d;
      licznik_q <= licznik_d;
      rejestr_q <= rejestr_d;
      dane_q    <= dane_d;
      wazne_q   <= wazne_d;
      blad_q    <= blad_d;
      przep_q   <= przep_d;
    end
  end

  assign dane             = dane_q;
  assign dane_wazne       = wazne_q;
  assign blad_parzystosci = blad_q;
  assign przepelnienie    = przep_q;
  assign zajety           = (stan_q != StBezczynny);

endmodule

// File: tb/tb_odbiornik_szeregowy.sv
// Bench for odbiornik_szeregowy (n=4): directed frames with literal
// expectations plus randomized traffic checked each cycle against a
// frame-level model (bit count, accumulated word, count of ones).
module tb_odbiornik_szeregowy;
  localparam int N = 4;

  logic         zegar = 1'b0;
  logic         reset = 1'b1;
  logic         swe = 1'b0;
  logic         swe_wazny = 1'b0;
  logic         wyczysc = 1'b0;
  logic         dane_gotowe = 1'b0;
  logic [N-1:0] dane;
  logic         dane_wazne, blad_parzystosci, przepelnienie, zajety;

  int n_checks = 0;
  int n_pass = 0;

  odbiornik_szeregowy #(.n(N)) dut (
    .zegar           (zegar),
    .reset           (reset),
    .swe             (swe),
    .swe_wazny       (swe_wazny),
    .wyczysc         (wyczysc),
    .dane            (dane),
    .dane_wazne      (dane_wazne),
    .dane_gotowe     (dane_gotowe),
    .blad_parzystosci(blad_parzystosci),
    .przepelnienie   (przepelnienie),
    .zajety          (zajety)
  );

  always #5 zegar = ~zegar;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // Frame-level model: m_cnt counts data bits seen after the start bit,
  // m_word accumulates them by weight, m_ones counts ones for parity.
  logic         m_busy, m_valid, m_err, m_ovf;
  int           m_cnt, m_ones;
  logic [N-1:0] m_word, m_data;
  wire          m_done = swe_wazny && m_busy && (m_cnt == N);

  always @(posedge zegar or negedge reset) begin
    if (!reset) begin
      m_busy <= 0; m_cnt <= 0; m_ones <= 0; m_word <= '0;
      m_valid <= 0; m_data <= '0; m_err <= 0; m_ovf <= 0;
    end else begin
      if (swe_wazny) begin
        if (!m_busy) begin
          if (swe) begin
            m_busy <= 1; m_cnt <= 0; m_word <= '0; m_ones <= 0;
          end
        end else if (m_cnt < N) begin
          if (swe) m_word <= m_word + N'(1 << m_cnt);
          m_ones <= m_ones + int'(swe);
          m_cnt  <= m_cnt + 1;
        end else begin
          m_busy <= 0;
        end
      end
      if (m_done && (!m_valid || dane_gotowe)) begin
        m_data  <= m_word;
        m_err   <= ((m_ones + int'(swe)) % 2) == 1;
        m_valid <= 1;
      end else if (m_valid && dane_gotowe) begin
        m_valid <= 0;
      end
      if (m_done && m_valid && !dane_gotowe) m_ovf <= 1;
      else if (wyczysc) m_ovf <= 0;
    end
  end

  always @(negedge zegar) begin
    check("valid", dane_wazne, m_valid);
    check("dane", dane, m_data);
    check("blad", blad_parzystosci, m_err);
    check("przep", przepelnienie, m_ovf);
    check("zajety", zajety, m_busy);
  end

  // Inputs change 1 time unit after the falling edge.
  task automatic cyc();
    @(negedge zegar);
    #1;
  endtask

  task automatic strobe(input logic b, input int gap);
    swe = b; swe_wazny = 1; cyc();
    swe_wazny = 0;
    repeat (gap) begin
      swe = ~swe; cyc();
    end
  endtask

  task automatic send_frame(input logic [N-1:0] w, input logic bad_par, input int gap);
    logic p;
    strobe(1'b1, gap);
    for (int i = 0; i < N; i++) strobe(w[i], gap);
    p = ^w ^ bad_par;
    strobe(p, gap);
  endtask

  initial begin
    logic [5:0] t1;
    #1 reset = 0;
    cyc();
    check("rst_dane", dane, 0);
    check("rst_valid", dane_wazne, 0);
    check("rst_zajety", zajety, 0);
    reset = 1;
    cyc();

    // 1: bits 1,1,1,0,1,1 -> 4'hB, good parity; zajety high after strobes 1..5
    t1 = 6'b110111;
    for (int k = 0; k < 6; k++) begin
      swe = t1[k]; swe_wazny = 1; cyc();
      check("t1_zajety", zajety, (k < 5) ? 1 : 0);
    end
    swe_wazny = 0;
    check("t1_dane", dane, 4'hB);
    check("t1_valid", dane_wazne, 1);
    check("t1_blad", blad_parzystosci, 0);
    dane_gotowe = 1; cyc(); dane_gotowe = 0;
    check("t1_consumed", dane_wazne, 0);

    // 2: same word, parity bit flipped
    send_frame(4'hB, 1'b1, 0);
    check("t2_dane", dane, 4'hB);
    check("t2_blad", blad_parzystosci, 1);
    check("t2_valid", dane_wazne, 1);
    dane_gotowe = 1; cyc(); dane_gotowe = 0;

    // 3: overrun
    send_frame(4'hB, 1'b0, 0);
    send_frame(4'h3, 1'b0, 0);
    check("t3_dane", dane, 4'hB);
    check("t3_przep", przepelnienie, 1);
    wyczysc = 1; cyc(); wyczysc = 0;
    check("t3_clr", przepelnienie, 0);
    dane_gotowe = 1; cyc(); dane_gotowe = 0;
    check("t3_valid", dane_wazne, 0);

    // 4: ready held, back-to-back frames
    dane_gotowe = 1;
    send_frame(4'hB, 1'b0, 0);
    check("t4_dane1", dane, 4'hB);
    check("t4_valid1", dane_wazne, 1);
    send_frame(4'h3, 1'b0, 0);
    check("t4_dane2", dane, 4'h3);
    check("t4_valid2", dane_wazne, 1);
    check("t4_przep", przepelnienie, 0);
    dane_gotowe = 0;
    cyc();

    // 5: reset mid-frame, then a clean frame
    strobe(1'b1, 0); strobe(1'b1, 0); strobe(1'b1, 0);
    reset = 0; #1;
    check("t5_dane", dane, 0);
    check("t5_valid", dane_wazne, 0);
    check("t5_zajety", zajety, 0);
    #1 reset = 1;
    cyc();
    send_frame(4'hB, 1'b0, 0);
    check("t5_dane2", dane, 4'hB);
    check("t5_blad2", blad_parzystosci, 0);
    dane_gotowe = 1; cyc(); dane_gotowe = 0;

    // 6: idle strobes, then spaced-out bits with toggling swe between them
    strobe(1'b0, 0); strobe(1'b0, 0);
    send_frame(4'hB, 1'b0, 3);
    check("t6_dane", dane, 4'hB);
    check("t6_valid", dane_wazne, 1);
    check("t6_blad", blad_parzystosci, 0);

    // Random traffic against the model
    for (int i = 0; i < 2000; i++) begin
      swe         = 1'($urandom_range(0, 1));
      swe_wazny   = ($urandom % 4) != 0;
      dane_gotowe = ($urandom % 3) == 0;
      wyczysc     = ($urandom % 16) == 0;
      if ($urandom % 300 == 0) begin
        reset = 0; #1 reset = 1;
      end
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
